// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, constants, FSM state encoding and the atan(2^-i)
// table used by the CORDIC vectoring engine.
// Build option: CORDIC_GAIN_COMP_EN adds the ST_COMP state (1/K magnitude scaling).
package cordic_pkg;

  localparam int IN_W  = 16;  // Q1.14 operands
  localparam int ANG_W = 16;  // Q3.12 angle output
  localparam int MAG_W = 18;  // Q3.14 magnitude output
  localparam int XY_W  = 19;  // internal x/y, headroom for negating -32768 and gain growth
  localparam int Z_W   = 18;  // internal angle accumulator, Q3.12
  localparam int CNT_W = 5;   // iteration counter, must reach 16
  localparam int LUT_N = 16;

  localparam logic signed [Z_W-1:0] PI_Q312 = 18'sd12868;
  localparam logic [15:0]           INV_K   = 16'd39797;  // 0.607253 * 2^16

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
`ifdef CORDIC_GAIN_COMP_EN
    ST_COMP = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_t;

  // atan(2^-i) in Q3.12, rounded to nearest
  localparam logic signed [Z_W-1:0] ATAN_TABLE [LUT_N] = '{
    18'sd3217, 18'sd1899, 18'sd1003, 18'sd509,
    18'sd256,  18'sd128,  18'sd64,   18'sd32,
    18'sd16,   18'sd8,    18'sd4,    18'sd2,
    18'sd1,    18'sd0,    18'sd0,    18'sd0
  };

endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational lookup of atan(2^-idx) in Q3.12.
module cordic_atan_lut
  import cordic_pkg::*;
(
  input  logic [3:0]            idx,
  output logic signed [Z_W-1:0] atan_val
);

  logic signed [Z_W-1:0] table_w [LUT_N];

  genvar gi;
  generate
    for (gi = 0; gi < LUT_N; gi++) begin : g_tab
      assign table_w[gi] = ATAN_TABLE[gi];
    end
  endgenerate

  assign atan_val = table_w[idx];

endmodule

// File: rtl/cordic_atan2.sv
// cordic_atan2: iterative CORDIC vectoring unit computing atan2(y, x) and the
// vector magnitude, one micro-rotation per clock, valid/ready on both sides.
// Build option: CORDIC_GAIN_COMP_EN scales the magnitude by 1/K in an extra
// ST_COMP cycle; without it the raw (K-scaled) magnitude is output.
module cordic_atan2
  import cordic_pkg::*;
#(
  parameter int ITER = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  x_in,
  input  logic signed [IN_W-1:0]  y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ANG_W-1:0] angle_out,
  output logic [MAG_W-1:0]        mag_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER);

  state_t                 state_reg, state_next;
  logic signed [XY_W-1:0] x_reg, y_reg;
  logic signed [Z_W-1:0]  z_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   zero_reg;
  logic signed [ANG_W-1:0] angle_reg;
  logic [MAG_W-1:0]       mag_reg;

  logic signed [XY_W-1:0] x_ext, y_ext, x_init, y_init;
  logic signed [XY_W-1:0] x_sh, y_sh, x_step, y_step;
  logic signed [Z_W-1:0]  z_init, z_step, z_clamp, atan_val;
  logic [MAG_W-1:0]       mag_raw;
`ifdef CORDIC_GAIN_COMP_EN
  logic [MAG_W+15:0]      mag_prod;
`endif

  cordic_atan_lut u_lut (
    .idx      (cnt_reg[3:0]),
    .atan_val (atan_val)
  );

  // Datapath: pre-rotation into the right half-plane, one micro-rotation, result shaping
  always_comb begin
    x_ext  = {{(XY_W-IN_W){x_in[IN_W-1]}}, x_in};
    y_ext  = {{(XY_W-IN_W){y_in[IN_W-1]}}, y_in};
    x_init = x_ext;
    y_init = y_ext;
    z_init = '0;
    if (x_in[IN_W-1]) begin
      x_init = -x_ext;
      y_init = -y_ext;
      z_init = y_in[IN_W-1] ? -PI_Q312 : PI_Q312;
    end

    x_sh = x_reg >>> cnt_reg;
    y_sh = y_reg >>> cnt_reg;
    if (!y_reg[XY_W-1]) begin
      x_step = x_reg + y_sh;
      y_step = y_reg - x_sh;
      z_step = z_reg + atan_val;
    end else begin
      x_step = x_reg - y_sh;
      y_step = y_reg + x_sh;
      z_step = z_reg - atan_val;
    end

    // A zero vector has no defined angle; the accumulator would drift, so force 0.
    if (zero_reg)             z_clamp = '0;
    else if (z_reg > PI_Q312) z_clamp = PI_Q312;
    else if (z_reg < -PI_Q312) z_clamp = -PI_Q312;
    else                      z_clamp = z_reg;

    // x stays non-negative after vectoring; its 19-bit signed range already tops out at 2^18-1.
    if (zero_reg || x_reg[XY_W-1]) mag_raw = '0;
    else                           mag_raw = x_reg[MAG_W-1:0];

`ifdef CORDIC_GAIN_COMP_EN
    mag_prod = ({{16{1'b0}}, mag_reg} * {{MAG_W{1'b0}}, INV_K}) + 34'd32768;
`endif
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = ST_ITER;
      ST_ITER: begin
        if (cnt_reg == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_next = ST_COMP;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_COMP: state_next = ST_DONE;
`endif
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign angle_out = angle_reg;
  assign mag_out   = mag_reg;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Operand capture, micro-rotations and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      cnt_reg   <= '0;
      zero_reg  <= 1'b0;
      angle_reg <= '0;
      mag_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg    <= x_init;
            y_reg    <= y_init;
            z_reg    <= z_init;
            cnt_reg  <= '0;
            zero_reg <= (x_in == '0) && (y_in == '0);
          end
        end
        ST_ITER: begin
          if (cnt_reg == LAST) begin
            angle_reg <= z_clamp[ANG_W-1:0];
            mag_reg   <= mag_raw;
          end else begin
            x_reg   <= x_step;
            y_reg   <= y_step;
            z_reg   <= z_step;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_COMP: mag_reg <= mag_prod[MAG_W+15:16];
`endif
        default: ;
      endcase
    end
  end

endmodule
